// File: rtl/uart_pkg.sv
// Shared constants for the uart_word_feeder slice:
// FSM encoding, word geometry and the byte picker.
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CLKS_PER_BIT   = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  function automatic logic [7:0] pick_byte(
    input logic [31:0] w,
    input logic [1:0]  idx,
    input logic        msb_first
  );
    logic [1:0] k;
    k = msb_first ? ~idx : idx;
    return 8'(w >> {k, 3'b000});
  endfunction

endpackage

// File: rtl/uart_word_feeder_if.sv
// Word handshake plus uart_tx control bundle
// between the datapath, the feeder and uart_tx.
interface uart_word_feeder_if;

  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        tx_enable;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        busy;
  logic        overflow;
  logic        tx_err;

  modport master (
    output word_in, word_valid, tx_done,
    input  word_ready, tx_enable, tx_byte,
    input  busy, overflow, tx_err
  );

  modport slave (
    input  word_in, word_valid, tx_done,
    output word_ready, tx_enable, tx_byte,
    output busy, overflow, tx_err
  );

endinterface

// File: rtl/word_fifo.sv
// DEPTH x 32 word FIFO with a registered count;
// full/empty are decoded from the count register.
module word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr;
  logic          do_rd;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rp_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + AW'(1);
      if (do_rd) rp_q <= rp_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wp_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_word_feeder.sv
// Buffers 32-bit words and feeds them byte by byte
// to uart_tx, pacing enable against tx_done.
module uart_word_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int TX_GAP    = 2,
  parameter int TIMEOUT   = 4095
) (
  input logic          clock,
  input logic          reset,
  uart_word_feeder_if.slave bus
);

  localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam logic [7:0]  GAP_LAST =
    8'((TX_GAP > 0) ? TX_GAP - 1 : 0);
  localparam logic [11:0] TO_LAST  = 12'(TIMEOUT - 1);

  logic        full;
  logic        empty;
  logic [31:0] rd_data;

  logic [2:0]  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [11:0] to_q, to_d;
  logic [7:0]  byte_q, byte_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (bus.word_valid),
    .wr_data_i (bus.word_in),
    .rd_en_i   (state_q == ST_IDLE),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.word_ready = !full;
  assign bus.tx_enable  = en_q;
  assign bus.tx_byte    = byte_q;
  assign bus.busy       = (state_q != ST_IDLE) || !empty;
  assign bus.overflow   = ovf_q;
  assign bus.tx_err     = err_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    to_d    = to_q;
    byte_d  = byte_q;
    en_d    = 1'b0;
    abort_d = abort_q;
    err_d   = err_q;
    ovf_d   = ovf_q | (bus.word_valid & full);
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          word_d  = rd_data;
          idx_d   = '0;
          abort_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        byte_d  = pick_byte(word_q, idx_q, MSB_FIRST);
        en_d    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (to_q == TO_LAST) begin
          // give up on the rest of this word
          err_d   = 1'b1;
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          to_d = to_q + 12'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q != LAST_IDX && !abort_q) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      byte_q  <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_word_feeder.sv
// Bench for uart_word_feeder: an LSB-first and an MSB-first instance,
// each answered by a frame-level uart_tx stand-in.
module tb_uart_word_feeder;
  import uart_pkg::*;

  localparam int DEPTH    = 4;
  localparam int TX_GAP   = 2;
  localparam int TIMEOUT  = 4095;
  localparam int FRAME    = 10 * CLKS_PER_BIT;
  localparam int WAIT_MAX = 10000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] w_in [2]    = '{32'h0, 32'h0};
  logic        w_valid [2] = '{1'b0, 1'b0};
  logic        done [2]    = '{1'b0, 1'b0};
  bit          dis [2]     = '{1'b0, 1'b0};
  logic        rdy [2];
  logic        en [2];
  logic        bsy [2];
  logic        ovf [2];
  logic        err [2];
  logic [7:0]  txb [2];
  logic [7:0]  expq [2][$];
  logic [7:0]  cap [2];
  logic        prev_en [2];
  int          rcnt [2];
  int          en_cnt [2] = '{0, 0};
  int          last_en_cyc [2];
  int          last_done_cyc [2];
  int          acc_cyc [2];
  int          cyc  = 0;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_word_feeder_if bus ();

    uart_word_feeder #(
      .DEPTH(DEPTH), .MSB_FIRST(g == 1),
      .TX_GAP(TX_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
      .clock(clock), .reset(reset), .bus(bus)
    );

    assign bus.word_in    = w_in[g];
    assign bus.word_valid = w_valid[g];
    assign bus.tx_done    = done[g];
    assign rdy[g] = bus.word_ready;
    assign en[g]  = bus.tx_enable;
    assign bsy[g] = bus.busy;
    assign ovf[g] = bus.overflow;
    assign err[g] = bus.tx_err;
    assign txb[g] = bus.tx_byte;

    // one frame per enable, tx_done at the end unless disconnected
    always @(negedge clock) begin
      done[g] = 1'b0;
      if (reset) begin
        rcnt[g]    = 0;
        prev_en[g] = 1'b0;
      end else begin
        if (bus.tx_enable) begin
          check("en_pulse", 32'(prev_en[g]), 32'd0);
          check("en_while_busy", 32'(rcnt[g] != 0), 32'd0);
          if (expq[g].size() == 0) begin
            check("spurious_byte", 32'(bus.tx_byte), 32'hFFFF_FFFF);
          end else begin
            check("byte", 32'(bus.tx_byte), 32'(expq[g].pop_front()));
          end
          cap[g]         = bus.tx_byte;
          rcnt[g]        = FRAME;
          en_cnt[g]      = en_cnt[g] + 1;
          last_en_cyc[g] = cyc;
        end else if (rcnt[g] != 0) begin
          rcnt[g] = rcnt[g] - 1;
          if (rcnt[g] == 0 && !dis[g]) begin
            check("byte_hold", 32'(bus.tx_byte), 32'(cap[g]));
            done[g]          = 1'b1;
            last_done_cyc[g] = cyc;
          end
        end
        prev_en[g] = bus.tx_enable;
      end
    end
  end

  task automatic expect_word(input int i, input logic [31:0] w);
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      int sh;
      sh = (i == 1) ? (BYTES_PER_WORD - 1 - k) : k;
      expq[i].push_back(8'(w >> (8 * sh)));
    end
  endtask

  task automatic push(input int i, input logic [31:0] w);
    int t = 0;
    while (!rdy[i] && t < WAIT_MAX) begin
      w_valid[i] = 1'b0;
      @(negedge clock);
      t++;
    end
    check("push_ready", 32'(rdy[i]), 32'd1);
    if (rdy[i]) begin
      w_in[i]    = w;
      w_valid[i] = 1'b1;
      acc_cyc[i] = cyc;
      expect_word(i, w);
    end else begin
      w_valid[i] = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (bsy[i] && t < WAIT_MAX) begin
      @(negedge clock);
      t++;
    end
    check("idle_reached", 32'(bsy[i]), 32'd0);
  endtask

  task automatic wait_en(input int i, input int n);
    int t = 0;
    while (en_cnt[i] < n && t < WAIT_MAX) begin
      @(negedge clock);
      t++;
    end
    check("enable_reached", 32'(en_cnt[i] >= n), 32'd1);
  endtask

  task automatic check_reset(input int i);
    check("rst_ready",    32'(rdy[i]), 32'd1);
    check("rst_enable",   32'(en[i]),  32'd0);
    check("rst_byte",     32'(txb[i]), 32'd0);
    check("rst_busy",     32'(bsy[i]), 32'd0);
    check("rst_overflow", 32'(ovf[i]), 32'd0);
    check("rst_err",      32'(err[i]), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish, expected finish by 80000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] w;

    repeat (3) @(negedge clock);
    check_reset(0);
    check_reset(1);
    reset = 1'b0;
    @(negedge clock);

    // single LSB-first word: EF BE AD DE
    push(0, 32'hDEADBEEF);
    w_valid[0] = 1'b0;
    wait_en(0, 1);
    check("latency", 32'(last_en_cyc[0] - acc_cyc[0]), 32'd3);
    wait_idle(0);
    check("busy_fall", 32'(cyc - last_done_cyc[0]), 32'(1 + TX_GAP));
    check("t1_enables", 32'(en_cnt[0]), 32'd4);
    check("t1_drained", 32'(expq[0].size()), 32'd0);

    // MSB-first word: 01 02 03 04
    push(1, 32'h01020304);
    w_valid[1] = 1'b0;
    wait_idle(1);
    check("t2_enables", 32'(en_cnt[1]), 32'd4);
    check("t2_drained", 32'(expq[1].size()), 32'd0);

    // back-to-back burst: first word moves to the shifter, 4 fill the FIFO
    base = en_cnt[0];
    for (int k = 0; k < 5; k++) push(0, $urandom);
    w_valid[0] = 1'b0;
    check("burst_full", 32'(rdy[0]), 32'd0);
    check("burst_no_ovf", 32'(ovf[0]), 32'd0);

    // rejected write while full
    w_in[0]    = 32'hBAD0BAD0;
    w_valid[0] = 1'b1;
    @(negedge clock);
    w_valid[0] = 1'b0;
    check("overflow_set", 32'(ovf[0]), 32'd1);
    wait_idle(0);
    check("burst_bytes", 32'(en_cnt[0] - base), 32'd20);
    check("burst_drained", 32'(expq[0].size()), 32'd0);
    check("overflow_sticky", 32'(ovf[0]), 32'd1);

    // tx_done disconnected: timeout abandons the word
    dis[0] = 1'b1;
    base = en_cnt[0];
    push(0, $urandom);
    w_valid[0] = 1'b0;
    begin
      int t = 0;
      while (!err[0] && t < WAIT_MAX) begin
        @(negedge clock);
        t++;
      end
    end
    check("tx_err_set", 32'(err[0]), 32'd1);
    check("timeout_delay", 32'(cyc - last_en_cyc[0]), 32'(TIMEOUT + 1));
    check("timeout_left", 32'(expq[0].size()), 32'd3);
    expq[0].delete();
    wait_idle(0);
    check("timeout_one_byte", 32'(en_cnt[0] - base), 32'd1);
    dis[0] = 1'b0;
    push(0, $urandom);
    w_valid[0] = 1'b0;
    wait_idle(0);
    check("after_to_drained", 32'(expq[0].size()), 32'd0);
    check("tx_err_sticky", 32'(err[0]), 32'd1);

    // async reset in the middle of byte 2
    base = en_cnt[0];
    push(0, $urandom);
    w_valid[0] = 1'b0;
    wait_en(0, base + 2);
    repeat (FRAME / 2) @(negedge clock);
    #3 reset = 1'b1;
    #1 check_reset(0);
    expq[0].delete();
    expq[1].delete();
    @(negedge clock);
    check_reset(0);
    check_reset(1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    base = en_cnt[0];
    w = $urandom;
    push(0, w);
    w_valid[0] = 1'b0;
    wait_en(0, base + 1);
    check("rst_latency", 32'(last_en_cyc[0] - acc_cyc[0]), 32'd3);
    wait_idle(0);
    check("rst_bytes", 32'(en_cnt[0] - base), 32'd4);
    check("rst_drained", 32'(expq[0].size()), 32'd0);

    // random traffic on both instances
    for (int n = 0; n < 16; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      push(i, $urandom);
      w_valid[i] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle(0);
    wait_idle(1);
    for (int i = 0; i < 2; i++) begin
      check("rand_drained", 32'(expq[i].size()), 32'd0);
      check("rand_no_ovf", 32'(ovf[i]), 32'd0);
      check("rand_no_err", 32'(err[i]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
